tile_map: RTL

- Holds the 20x15 solid-tile bitmap (32 px tiles) that the player-physics block uses for floor and ceiling collision.
- Serves two consumers:
  - the raster painter, through a pipelined per-pixel lookup;
  - the physics block, through a one-per-cycle collision query handshake.
- Builds a default level after reset. Accepts single-tile edits at runtime.

---
 rtl/tile_pkg.sv | 32 +++
 rtl/tile_map_query.sv | 89 ++++++++
 rtl/tile_map.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared constants, types and the default-level pattern for the tile map.
// The map is MAP_H rows of MAP_W bits; bit c of a row vector is column c.
// ---------------------------------------------------------------------------
package tile_pkg;

    localparam int TILE_SHIFT = 5;
    localparam int TILE_SIZE  = 32;
    localparam int MAP_W      = 20;
    localparam int MAP_H      = 15;

    typedef logic [4:0]       tile_col_t;
    typedef logic [3:0]       tile_row_t;
    typedef logic [MAP_W-1:0] map_row_t;

    // Default level built row by row after reset: a full floor on the last
    // row, a mid-height platform and a higher, shorter ledge.
    function automatic map_row_t default_row(input tile_row_t row);
        map_row_t bits;
        bits = '0;
        if (row == tile_row_t'(MAP_H - 1)) begin
            bits = '1;
        end else if (row == tile_row_t'(MAP_H - 5)) begin
            for (int c = 6; c <= 11; c++) bits[c] = 1'b1;
        end else if (row == tile_row_t'(MAP_H - 9)) begin
            for (int c = 12; c <= 15; c++) bits[c] = 1'b1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/tile_map_query.sv
// ---------------------------------------------------------------------------
// tile_query
// Collision query path for the physics block. Classifies a signed query
// position against the screen bounds, looks up the addressed tile and
// registers a one-cycle response.
//
// Ports:
//   clk_pix, rst_pix  clock and async active-high reset
//   init_done         map is built; queries are accepted only when high
//   q_valid/q_ready   query handshake (q_ready mirrors init_done)
//   q_x, q_y          signed query pixel position
//   rd_col, rd_row    tile address presented to the map storage
//   rd_bits           row vector returned by the storage for rd_row
//   r_valid, r_solid  response strobe and held result
// ---------------------------------------------------------------------------
module tile_query
    import tile_pkg::*;
#(
    parameter int QW    = 12,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix,
    input  logic                 init_done,
    input  logic                 q_valid,
    output logic                 q_ready,
    input  logic signed [QW-1:0] q_x,
    input  logic signed [QW-1:0] q_y,
    output tile_col_t            rd_col,
    output tile_row_t            rd_row,
    input  map_row_t             rd_bits,
    output logic                 r_valid,
    output logic                 r_solid
);

    localparam logic signed [QW-1:0] X_LIM = QW'(H_RES);
    localparam logic signed [QW-1:0] Y_LIM = QW'(V_RES);

    logic accept;
    logic solid_now;
    logic x_out;
    logic y_below;
    logic y_sky;
    logic map_bit;

    assign q_ready = init_done;
    assign accept  = q_valid && q_ready;

    // Tile address is only meaningful once the range checks below have
    // confirmed the position is on-screen and non-negative.
    assign rd_col = q_x[TILE_SHIFT +: 5];
    assign rd_row = q_y[TILE_SHIFT +: 4];

    assign x_out   = q_x[QW-1] || (q_x >= X_LIM);
    assign y_below = (q_y >= Y_LIM);
    assign y_sky   = q_y[QW-1];
    assign map_bit = (rd_col < tile_col_t'(MAP_W)) ? rd_bits[rd_col] : 1'b0;

    // Side walls win over sky so a player cannot escape sideways above the
    // screen; below the floor is always solid; above the screen is open.
    always_comb begin
        solid_now = 1'b0;
        if (x_out) begin
            solid_now = 1'b1;
        end else if (y_below) begin
            solid_now = 1'b1;
        end else if (y_sky) begin
            solid_now = 1'b0;
        end else begin
            solid_now = map_bit;
        end
    end

    // The response reads the map before any same-edge write lands, giving
    // read-before-write ordering. r_solid holds between responses.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_valid <= 1'b0;
            r_solid <= 1'b0;
        end else begin
            r_valid <= accept;
            if (accept) begin
                r_solid <= solid_now;
            end
        end
    end

endmodule

// File: rtl/tile_map.sv
// ---------------------------------------------------------------------------
// tile_map
// Solid-tile bitmap (MAP_W x MAP_H tiles of 32 px) shared by the raster
// painter and the player-physics block. Builds the default level one row
// per cycle after reset, then serves render lookups, collision queries and
// single-tile edits.
//
// Ports:
//   clk_pix, rst_pix         pixel clock, async active-high reset
//   init_done                map built, query and write ports live
//   sx, sy                   raster position
//   tile_solid, tile_edge    render lookup, 2-cycle latency
//   q_valid, q_ready         collision query handshake
//   q_x, q_y                 signed query position
//   r_valid, r_solid         collision response
//   w_en, w_col, w_row, w_val  single-tile write
// ---------------------------------------------------------------------------
module tile_map
    import tile_pkg::*;
#(
    parameter int CORDW = 10,
    parameter int QW    = 12,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix,
    output logic                 init_done,
    input  logic [CORDW-1:0]     sx,
    input  logic [CORDW-1:0]     sy,
    output logic                 tile_solid,
    output logic                 tile_edge,
    input  logic                 q_valid,
    output logic                 q_ready,
    input  logic signed [QW-1:0] q_x,
    input  logic signed [QW-1:0] q_y,
    output logic                 r_valid,
    output logic                 r_solid,
    input  logic                 w_en,
    input  tile_col_t            w_col,
    input  tile_row_t            w_row,
    input  logic                 w_val
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CORDW-1:0] SX_LIM = CORDW'(H_RES);
    localparam logic [CORDW-1:0] SY_LIM = CORDW'(V_RES);

    logic [0:0] state;
    tile_row_t  init_row;
    map_row_t   map [MAP_H];

    tile_col_t  s1_col;
    tile_row_t  s1_row;
    logic       s1_in_range;
    logic       s1_edge;
    map_row_t   s1_bits;
    logic       s1_bit;

    tile_col_t  rd_col;
    tile_row_t  rd_row;
    map_row_t   rd_bits;

    logic       wr_ok;

    assign init_done = (state == ST_RUN);

    // Build the level from row 0 upward; the final row write moves to RUN,
    // so the map is complete on the first RUN cycle.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state    <= ST_INIT;
            init_row <= '0;
        end else if (state == ST_INIT) begin
            if (init_row == tile_row_t'(MAP_H - 1)) begin
                state <= ST_RUN;
            end else begin
                init_row <= init_row + 1'b1;
            end
        end
    end

    assign wr_ok = w_en && (state == ST_RUN)
                   && (w_row < tile_row_t'(MAP_H))
                   && (w_col < tile_col_t'(MAP_W));

    // Map storage is plain flops with no reset: INIT rewrites every row, and
    // both consumers are gated by init_done until that has happened.
    always_ff @(posedge clk_pix) begin
        if (state == ST_INIT) begin
            map[init_row] <= default_row(init_row);
        end else if (wr_ok) begin
            map[w_row][w_col] <= w_val;
        end
    end

    // Render stage 1: tile address, on-screen flag and border flag.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            s1_col      <= '0;
            s1_row      <= '0;
            s1_in_range <= 1'b0;
            s1_edge     <= 1'b0;
        end else begin
            s1_col      <= sx[TILE_SHIFT +: 5];
            s1_row      <= sy[TILE_SHIFT +: 4];
            s1_in_range <= (sx < SX_LIM) && (sy < SY_LIM);
            s1_edge     <= (sx[TILE_SHIFT-1:0] == '0) || (sx[TILE_SHIFT-1:0] == '1)
                           || (sy[TILE_SHIFT-1:0] == '0) || (sy[TILE_SHIFT-1:0] == '1);
        end
    end

    assign s1_bits = (s1_row < tile_row_t'(MAP_H)) ? map[s1_row] : '0;
    assign s1_bit  = (s1_col < tile_col_t'(MAP_W)) ? s1_bits[s1_col] : 1'b0;

    // Render stage 2: off-screen pixels and a half-built map read as empty.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            tile_solid <= 1'b0;
            tile_edge  <= 1'b0;
        end else begin
            tile_solid <= s1_in_range && s1_bit && init_done;
            tile_edge  <= s1_in_range && s1_edge;
        end
    end

    assign rd_bits = (rd_row < tile_row_t'(MAP_H)) ? map[rd_row] : '0;

    tile_query #(
        .QW    (QW),
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_query (
        .clk_pix   (clk_pix),
        .rst_pix   (rst_pix),
        .init_done (init_done),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_x       (q_x),
        .q_y       (q_y),
        .rd_col    (rd_col),
        .rd_row    (rd_row),
        .rd_bits   (rd_bits),
        .r_valid   (r_valid),
        .r_solid   (r_solid)
    );

endmodule
